timer_ctrl: RTL and testbench

Programmable timebase controller that sits directly upstream of the counter register in a peripheral timer. It owns a prescaler, a match comparator and a small CPU-visible register file, and drives the counter's count-enable, write-enable and write-data inputs while watching the counter's output. Raises a match flag and an interrupt request on each compare event, in auto-reload or one-shot mode.

---
 rtl/timer_ctrl_if.sv | 12 +
 rtl/timer_ctrl.sv | 89 ++++++++
 tb/tb_timer_ctrl.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/timer_ctrl_if.sv
// CPU register bus of timer_ctrl: select, strobe, address, write data and
// combinational read data.
interface timer_ctrl_if #(parameter int WIDTH = 32);
   logic             cs;
   logic             wr;
   logic [1:0]       addr;
   logic [WIDTH-1:0] wdata;
   logic [WIDTH-1:0] rdata;

   modport master (output cs, wr, addr, wdata, input rdata);
   modport slave  (input cs, wr, addr, wdata, output rdata);
endinterface

// File: rtl/timer_ctrl.sv
// Timebase controller for a peripheral timer: prescaler, match comparator and
// CPU register file, driving the counter's enable/load inputs.
module timer_ctrl #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   timer_ctrl_if.slave      bus,
   input  logic [WIDTH-1:0] cnt_q,
   output logic             cnt_cen,
   output logic             cnt_wen,
   output logic [WIDTH-1:0] cnt_din,
   output logic             irq
);

   logic             en, reload, ie, clr_pulse, matchf;
   logic [15:0]      prescale, pre_cnt;
   logic [WIDTH-1:0] match_r;
   logic [WIDTH-1:0] rdata_c;
   logic             wr_ctrl, wr_pre, wr_match, wr_stat;
   logic             tick, match;

   assign wr_ctrl  = bus.cs & bus.wr & (bus.addr == 2'd0);
   assign wr_pre   = bus.cs & bus.wr & (bus.addr == 2'd1);
   assign wr_match = bus.cs & bus.wr & (bus.addr == 2'd2);
   assign wr_stat  = bus.cs & bus.wr & (bus.addr == 2'd3);

   // A pending CLR beats the compare: the counter is being zeroed this tick.
   assign tick    = en & (pre_cnt == prescale);
   assign match   = tick & ~clr_pulse & (cnt_q == match_r);
   assign cnt_cen = tick & ~match & ~clr_pulse;
   assign cnt_wen = (match & reload) | clr_pulse;
   assign cnt_din = '0;
   assign irq     = matchf & ie;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pre_cnt <= '0;
      end else if (wr_ctrl | wr_pre | ~en | tick) begin
         pre_cnt <= '0;
      end else begin
         pre_cnt <= pre_cnt + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         en        <= 1'b0;
         reload    <= 1'b0;
         ie        <= 1'b0;
         clr_pulse <= 1'b0;
         prescale  <= '0;
         match_r   <= '0;
      end else begin
         clr_pulse <= wr_ctrl & bus.wdata[3];
         // CPU write to CTRL overrides the one-shot self-disable.
         if (wr_ctrl) begin
            en     <= bus.wdata[0];
            reload <= bus.wdata[1];
            ie     <= bus.wdata[2];
         end else if (match & ~reload) begin
            en <= 1'b0;
         end
         if (wr_pre)   prescale <= bus.wdata[15:0];
         if (wr_match) match_r  <= bus.wdata;
      end
   end

   // Hardware set wins over a coincident software clear.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)                        matchf <= 1'b0;
      else if (match)                    matchf <= 1'b1;
      else if (wr_stat & bus.wdata[0])   matchf <= 1'b0;
   end

   always_comb begin
      rdata_c = '0;
      case (bus.addr)
         2'd0: rdata_c[2:0]  = {ie, reload, en};
         2'd1: rdata_c[15:0] = prescale;
         2'd2: rdata_c       = match_r;
         2'd3: rdata_c[1:0]  = {en, matchf};
         default: rdata_c    = '0;
      endcase
   end

   assign bus.rdata = rdata_c;

endmodule

// File: tb/tb_timer_ctrl.sv
// Bench for timer_ctrl: directed scenarios plus random register traffic, all
// checked every cycle against a countdown-based reference model.
module tb_timer_ctrl;
   localparam int W = 32;

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic [W-1:0] cnt_q;
   logic         cnt_cen, cnt_wen, irq;
   logic [W-1:0] cnt_din;

   timer_ctrl_if #(.WIDTH(W)) bus ();

   timer_ctrl #(.WIDTH(W)) dut (
      .clk     (clk),
      .reset   (reset),
      .bus     (bus),
      .cnt_q   (cnt_q),
      .cnt_cen (cnt_cen),
      .cnt_wen (cnt_wen),
      .cnt_din (cnt_din),
      .irq     (irq)
   );

   always #5 clk = ~clk;

   // The controlled counter itself.
   always @(posedge clk or negedge reset) begin
      if (!reset)       cnt_q <= '0;
      else if (cnt_wen) cnt_q <= cnt_din;
      else if (cnt_cen) cnt_q <= cnt_q + 1;
   end

   int n_chk = 0, n_err = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: rem = clocks left until the next tick.
   bit          m_en, m_rel, m_ie, m_clr, m_flag;
   logic [15:0] m_pre, m_rem;
   logic [W-1:0] m_mat, m_cnt;

   task automatic model_reset();
      m_en = 0; m_rel = 0; m_ie = 0; m_clr = 0; m_flag = 0;
      m_pre = 0; m_rem = 0; m_mat = 0; m_cnt = 0;
   endtask

   function automatic bit pred_match();
      return m_en && m_rem == 0 && !m_clr && m_cnt == m_mat;
   endfunction

   int  ncyc = 0, cen_seen = 0, last_wen = -1, period = 0;
   bit  obs_cen, obs_wen;
   logic [W-1:0] obs_rd;

   task automatic cyc(input bit c, input bit w, input logic [1:0] a, input logic [W-1:0] d);
      bit tk, mt, ecen, ewen;
      logic [W-1:0] erd;
      bus.cs = c; bus.wr = w; bus.addr = a; bus.wdata = d;
      @(negedge clk);
      tk   = m_en && m_rem == 0;
      mt   = pred_match();
      ecen = tk && !mt && !m_clr;
      ewen = (mt && m_rel) || m_clr;
      case (a)
         2'd0: erd = {29'd0, m_ie, m_rel, m_en};
         2'd1: erd = {16'd0, m_pre};
         2'd2: erd = m_mat;
         default: erd = {30'd0, m_en, m_flag};
      endcase
      chk("cnt_cen", cnt_cen, ecen);
      chk("cnt_wen", cnt_wen, ewen);
      chk("cnt_din", cnt_din, 0);
      chk("irq", irq, m_flag && m_ie);
      chk("rdata", bus.rdata, erd);
      chk("cnt_q", cnt_q, m_cnt);
      obs_cen = cnt_cen; obs_wen = cnt_wen; obs_rd = bus.rdata;
      if (cnt_cen) cen_seen++;
      if (cnt_wen) begin
         if (last_wen >= 0) period = ncyc - last_wen;
         last_wen = ncyc;
      end
      @(posedge clk);
      if (ewen) m_cnt = 0;
      else if (ecen) m_cnt = m_cnt + 1;
      if (mt) m_flag = 1;
      else if (c && w && a == 3 && d[0]) m_flag = 0;
      if (c && w && a == 1) m_pre = d[15:0];
      if (c && w && a == 2) m_mat = d;
      m_clr = c && w && a == 0 && d[3];
      if (c && w && a == 0) begin
         m_en = d[0]; m_rel = d[1]; m_ie = d[2];
      end else if (mt && !m_rel) m_en = 0;
      if ((c && w && (a == 0 || a == 1)) || !m_en || m_rem == 0 || tk) m_rem = m_pre;
      else m_rem = m_rem - 1;
      #1;
      ncyc++;
   endtask

   task automatic idle(input int n, input logic [1:0] a);
      for (int i = 0; i < n; i++) cyc(0, 0, a, 0);
   endtask

   task automatic check_reset_state(input string tag);
      bus.cs = 0; bus.wr = 0;
      for (int a = 0; a < 4; a++) begin
         bus.addr = a[1:0];
         #1;
         chk({tag, "_rdata"}, bus.rdata, 0);
      end
      chk({tag, "_cen"}, cnt_cen, 0);
      chk({tag, "_wen"}, cnt_wen, 0);
      chk({tag, "_irq"}, irq, 0);
   endtask

   int k;

   initial begin
      bus.cs = 0; bus.wr = 0; bus.addr = 0; bus.wdata = 0;
      model_reset();
      #2;
      check_reset_state("por");
      @(posedge clk); #1 reset = 1'b1;

      // Auto-reload: PRESCALE=2, MATCH=3 gives a 12-cycle period.
      cyc(1, 1, 1, 2);
      cyc(1, 1, 2, 3);
      cyc(1, 1, 0, 7);
      idle(40, 3);
      chk("ar_period", period, 12);
      chk("ar_irq", irq, 1);

      // Asynchronous reset mid-count.
      #2 reset = 1'b0;
      #1;
      check_reset_state("mid");
      model_reset();
      @(posedge clk); #1 reset = 1'b1;

      // One-shot at PRESCALE=0.
      cyc(1, 1, 2, 5);
      cen_seen = 0;
      cyc(1, 1, 0, 1);
      idle(15, 3);
      chk("os_pulses", cen_seen, 5);
      chk("os_status", obs_rd, 1);
      chk("os_cnt", cnt_q, 5);

      // Software clear on the same edge as a match: set wins.
      cyc(1, 1, 2, 3);
      cyc(1, 1, 0, 15);
      for (int i = 0; i < 20; i++) begin
         if (pred_match()) begin cyc(1, 1, 3, 1); break; end
         cyc(0, 0, 0, 0);
      end
      cyc(0, 0, 3, 0);
      chk("race_flag", obs_rd[0], 1);
      cyc(1, 1, 0, 4);
      cyc(1, 1, 3, 1);
      cyc(0, 0, 3, 0);
      chk("clear_flag", obs_rd[0], 0);
      chk("clear_irq", irq, 0);

      // CLR coincident with a tick at counter value 2.
      cyc(1, 1, 2, 100);
      cyc(1, 1, 0, 9);
      for (int i = 0; i < 10 && m_cnt != 2; i++) cyc(0, 0, 0, 0);
      cyc(1, 1, 0, 11);
      cyc(0, 0, 0, 0);
      chk("clr_wen", obs_wen, 1);
      chk("clr_cen", obs_cen, 0);
      chk("clr_cnt", cnt_q, 0);

      // Prescaler restart: PRESCALE=9 written while pre_cnt is 7.
      cyc(1, 1, 0, 0);
      cyc(1, 1, 2, 1000);
      cyc(1, 1, 1, 15);
      cyc(1, 1, 0, 1);
      for (int i = 0; i < 20 && m_rem != 8; i++) cyc(0, 0, 1, 0);
      cyc(1, 1, 1, 9);
      k = 0;
      do begin
         k++;
         cyc(0, 0, 1, 0);
      end while (!obs_cen && k < 30);
      chk("pre_restart", k, 10);

      // Random register traffic.
      for (int i = 0; i < 800; i++) begin
         logic [1:0]   a;
         logic [W-1:0] d;
         a = 2'($urandom_range(0, 3));
         case (a)
            2'd0: d = $urandom_range(0, 15);
            2'd1: d = $urandom_range(0, 3);
            2'd2: d = $urandom_range(0, 7);
            default: d = $urandom_range(0, 1);
         endcase
         if ($urandom_range(0, 5) == 0) cyc(1, 1, a, d);
         else cyc($urandom_range(0, 1) == 1, 0, a, d);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
      $finish;
   end

endmodule
